// File: rtl/fsk_zc_demod_p.sv
// Zero-crossing FSK demodulator: hysteresis comparator, per-window crossing count, bit decision one cycle after the closing sample.
// No backpressure: a sample is consumed whenever sample_valid=1. FSK_DEGLITCH_EN adds a 2-window agreement filter on bit_out.
module fsk_zc_demod_p #(
    parameter int DATA_W       = 8,
    parameter int MIDPOINT     = 128,
    parameter int HYST         = 8,
    parameter int WINDOW_LEN   = 64,
    parameter int CROSS_THRESH = 12,
    parameter int MIN_CROSS    = 2,
    localparam int CW          = $clog2(WINDOW_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic              win_restart,
    output logic              bit_out,
    output logic              bit_valid,
    output logic [CW-1:0]     cross_count,
    output logic              carrier_ok
);

    localparam int MAXV   = (1 << DATA_W) - 1;
    localparam int HI_RAW = MIDPOINT + HYST;
    localparam int LO_RAW = MIDPOINT - HYST;
    localparam int HI_TH  = (HI_RAW > MAXV) ? MAXV : HI_RAW;
    localparam int LO_TH  = (LO_RAW < 0) ? 0 : LO_RAW;

    localparam logic [DATA_W-1:0] HI_V  = DATA_W'(HI_TH);
    localparam logic [DATA_W-1:0] LO_V  = DATA_W'(LO_TH);
    localparam logic [DATA_W-1:0] MID_V = DATA_W'(MIDPOINT);
    localparam logic [CW-1:0]     WL_V  = CW'(WINDOW_LEN);
    localparam logic [CW-1:0]     WLM1  = CW'(WINDOW_LEN - 1);

    logic          r_init;
    logic          r_level;
    logic [CW-1:0] r_win_cnt;
    logic [CW-1:0] r_xc;
    logic          r_bit_out;
    logic          r_bit_valid;
    logic [CW-1:0] r_cross_count;
    logic          r_carrier_ok;
`ifdef FSK_DEGLITCH_EN
    logic          r_hist;
`endif

    logic          w_level_next;
    logic          w_cross;
    logic [CW-1:0] w_xc_next;
    logic          w_close;
    logic          w_dec;
    logic          w_carrier;

    always_comb begin
        w_level_next = r_level;
        if (!r_init)
            w_level_next = (sample >= MID_V);
        else if (sample >= HI_V)
            w_level_next = 1'b1;
        else if (sample <= LO_V)
            w_level_next = 1'b0;
    end

    // The first sample after reset only seeds the level, so it can never count as a crossing.
    assign w_cross   = r_init && (w_level_next != r_level);
    assign w_xc_next = (w_cross && (r_xc != WL_V)) ? r_xc + 1'b1 : r_xc;
    assign w_close   = sample_valid && !win_restart && (r_win_cnt == WLM1);
    assign w_dec     = int'(w_xc_next) >= CROSS_THRESH;
    assign w_carrier = int'(w_xc_next) >= MIN_CROSS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init        <= 1'b0;
            r_level       <= 1'b0;
            r_win_cnt     <= '0;
            r_xc          <= '0;
            r_bit_out     <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_cross_count <= '0;
            r_carrier_ok  <= 1'b0;
`ifdef FSK_DEGLITCH_EN
            r_hist        <= 1'b0;
`endif
        end else begin
            r_bit_valid <= 1'b0;
            if (sample_valid) begin
                r_level <= w_level_next;
                r_init  <= 1'b1;
            end
            // Restart wins over a coinciding close: the window in flight is dropped undecided.
            if (win_restart) begin
                r_win_cnt <= '0;
                r_xc      <= '0;
`ifdef FSK_DEGLITCH_EN
                r_hist    <= 1'b0;
`endif
            end else if (sample_valid) begin
                if (w_close) begin
                    r_win_cnt     <= '0;
                    r_xc          <= '0;
                    r_bit_valid   <= 1'b1;
                    r_cross_count <= w_xc_next;
                    r_carrier_ok  <= w_carrier;
`ifdef FSK_DEGLITCH_EN
                    r_hist        <= w_dec;
                    if (w_dec == r_hist)
                        r_bit_out <= w_dec;
`else
                    r_bit_out     <= w_dec;
`endif
                end else begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    r_xc      <= w_xc_next;
                end
            end
        end
    end

    assign bit_out     = r_bit_out;
    assign bit_valid   = r_bit_valid;
    assign cross_count = r_cross_count;
    assign carrier_ok  = r_carrier_ok;

endmodule

// File: tb/tb_fsk_zc_demod_p.sv
// Directed bench for fsk_zc_demod_p with default parameters; decision-sequence expectations follow FSK_DEGLITCH_EN.
module tb_fsk_zc_demod_p;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample = 8'd0;
    logic       win_restart = 1'b0;
    logic       bit_out;
    logic       bit_valid;
    logic [6:0] cross_count;
    logic       carrier_ok;

    int n_total = 0;
    int n_bad = 0;
    int n_strobe = 0;

    fsk_zc_demod_p dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .win_restart(win_restart), .bit_out(bit_out), .bit_valid(bit_valid),
        .cross_count(cross_count), .carrier_ok(carrier_ok)
    );

    always #5 clk = ~clk;

    // kind 0: const 100, 1: period-8 tone, 2: period-16 tone, 3: const 128
    function automatic logic [7:0] pat(input int kind, input int idx);
        case (kind)
            0: return 8'd100;
            1: return (((idx / 4) % 2) == 0) ? 8'd156 : 8'd100;
            2: return (((idx / 8) % 2) == 0) ? 8'd156 : 8'd100;
            default: return 8'd128;
        endcase
    endfunction

    task automatic feed(input logic [7:0] v, input logic rs);
        sample = v;
        sample_valid = 1'b1;
        win_restart = rs;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        win_restart = 1'b0;
        if (bit_valid === 1'b1) n_strobe++;
    endtask

    task automatic feed_win(input int kind);
        for (int i = 0; i < 64; i++) feed(pat(kind, i), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_strobe = 0;
    endtask

    task automatic check_win(input string nm, input int exp_strobe, input int exp_cc,
                             input logic exp_bit, input logic exp_car);
        n_total++;
        if (n_strobe !== exp_strobe) begin
            n_bad++;
            $display("FAIL %s_strobes got=%0d exp=%0d", nm, n_strobe, exp_strobe);
        end
        n_total++;
        if (cross_count !== 7'(exp_cc)) begin
            n_bad++;
            $display("FAIL %s_cross got=%0d exp=%0d", nm, cross_count, exp_cc);
        end
        n_total++;
        if (bit_out !== exp_bit || carrier_ok !== exp_car) begin
            n_bad++;
            $display("FAIL %s_bit_car got=%b/%b exp=%b/%b", nm, bit_out, carrier_ok, exp_bit, exp_car);
        end
    endtask

    task automatic test_reset();
        #3;
        n_total++;
        if ({bit_out, bit_valid, cross_count, carrier_ok} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b exp=0", {bit_out, bit_valid, cross_count, carrier_ok});
        end
        do_reset();
    endtask

    task automatic test_constant();
        do_reset();
        for (int i = 0; i < 63; i++) feed(8'd128, 1'b0);
        n_total++;
        if (n_strobe !== 0) begin
            n_bad++;
            $display("FAIL const_early_strobe got=%0d exp=0", n_strobe);
        end
        feed(8'd128, 1'b0);
        check_win("const", 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_tones();
        do_reset();
        feed_win(1);
        check_win("sq8", 1, 15, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (bit_valid !== 1'b0 || cross_count !== 7'd15 || bit_out !== 1'b1) begin
                n_bad++;
                $display("FAIL hold got=%b/%0d/%b exp=0/15/1", bit_valid, cross_count, bit_out);
            end
        end
        do_reset();
        feed_win(2);
        check_win("sq16", 1, 7, 1'b0, 1'b1);
    endtask

    task automatic test_hysteresis();
        do_reset();
        feed(8'd156, 1'b0);
        for (int i = 1; i < 64; i++) feed((i % 2) ? 8'd125 : 8'd131, 1'b0);
        check_win("dither", 1, 0, 1'b0, 1'b0);
        feed(8'd119, 1'b0);
        feed(8'd137, 1'b0);
        for (int i = 2; i < 64; i++) feed((i % 2) ? 8'd125 : 8'd131, 1'b0);
        check_win("swing", 2, 2, 1'b0, 1'b1);
        feed(8'd120, 1'b0);
        feed(8'd136, 1'b0);
        feed(8'd120, 1'b0);
        for (int i = 3; i < 64; i++) feed((i % 2) ? 8'd121 : 8'd135, 1'b0);
        check_win("edges", 3, 3, 1'b0, 1'b1);
    endtask

    task automatic test_closing_crossing();
        do_reset();
        for (int i = 0; i < 63; i++) feed(8'd156, 1'b0);
        feed(8'd100, 1'b0);
        check_win("close_xc", 1, 1, 1'b0, 1'b0);
        feed_win(0);
        check_win("after_close", 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        feed_win(0);
        for (int i = 0; i < 64; i++) feed((i % 2) ? 8'd100 : 8'd156, 1'b0);
        check_win("every_sample", 2, 64, 1'b1, 1'b1);
    endtask

    task automatic test_restart();
        do_reset();
        for (int i = 0; i < 30; i++) feed(pat(1, i), 1'b0);
        feed(pat(1, 30), 1'b1);
        for (int i = 31; i < 94; i++) feed(pat(1, i), 1'b0);
        n_total++;
        if (n_strobe !== 0) begin
            n_bad++;
            $display("FAIL restart_old_boundary got=%0d exp=0", n_strobe);
        end
        feed(pat(1, 94), 1'b0);
        check_win("restart", 1, 16, 1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 63; i++) feed(pat(1, i), 1'b0);
        feed(8'd100, 1'b1);
        n_total++;
        if (n_strobe !== 0 || bit_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_on_close got=%0d/%b exp=0/0", n_strobe, bit_valid);
        end
        feed_win(0);
        check_win("post_discard", 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        feed_win(1);
        check_win("pre_rst", 1, 15, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) feed(pat(1, i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({bit_out, bit_valid, cross_count, carrier_ok} !== 10'd0) begin
            n_bad++;
            $display("FAIL async_rst got=%b exp=0", {bit_out, bit_valid, cross_count, carrier_ok});
        end
        @(negedge clk);
        rst = 1'b0;
        n_strobe = 0;
        for (int i = 0; i < 63; i++) feed(pat(1, i), 1'b0);
        n_total++;
        if (n_strobe !== 0) begin
            n_bad++;
            $display("FAIL rst_early_strobe got=%0d exp=0", n_strobe);
        end
        feed(pat(1, 63), 1'b0);
        check_win("post_rst", 1, 15, 1'b1, 1'b1);
    endtask

    task automatic test_decisions();
        int   kinds[5] = '{0, 1, 0, 1, 1};
`ifdef FSK_DEGLITCH_EN
        logic exp_b[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        logic exp_b[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        do_reset();
        for (int w = 0; w < 5; w++) begin
            feed_win(kinds[w]);
            n_total++;
            if (bit_out !== exp_b[w] || n_strobe !== w + 1) begin
                n_bad++;
                $display("FAIL decision_%0d got=%b/%0d exp=%b/%0d", w, bit_out, n_strobe, exp_b[w], w + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_tones();
        test_hysteresis();
        test_closing_crossing();
        test_back_to_back();
        test_restart();
        test_mid_reset();
        test_decisions();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
